transmission_estimator: RTL

Per-pixel transmission-map stage of the dehaze pipeline, downstream of atmospheric light estimation. It consumes the same 3x3 RGB windows plus the per-frame inverse atmospheric light (Q0.16), and computes t = max(1 − ω·min_c(min_window(I_c)/A_c), t0) as Q0.16. The A and 1/A values are double-buffered, so estimates gathered during frame k are applied to frame k+1. The delayed centre pixel and active A are forwarded to the scene-recovery stage.

---
 rtl/transmission_estimator.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/transmission_estimator.sv
// Dehaze transmission-map stage: t = max(1 - omega*min_c(min3x3(I_c)/A_c), t0) in Q0.16,
// with double-buffered A / 1/A banks swapped at frame boundaries.
module transmission_estimator #(
   parameter int unsigned OMEGA_Q8 = 243,
   parameter int unsigned T0_Q16   = 6554
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [23:0] in_pixel_1,
   input  logic [23:0] in_pixel_2,
   input  logic [23:0] in_pixel_3,
   input  logic [23:0] in_pixel_4,
   input  logic [23:0] in_pixel_5,
   input  logic [23:0] in_pixel_6,
   input  logic [23:0] in_pixel_7,
   input  logic [23:0] in_pixel_8,
   input  logic [23:0] in_pixel_9,
   input  logic        a_valid,
   input  logic [7:0]  a_r,
   input  logic [7:0]  a_g,
   input  logic [7:0]  a_b,
   input  logic [15:0] inv_a_r,
   input  logic [15:0] inv_a_g,
   input  logic [15:0] inv_a_b,
   input  logic        frame_start,
   output logic        out_valid,
   output logic [15:0] t_out,
   output logic [23:0] centre_out,
   output logic [7:0]  act_a_r,
   output logic [7:0]  act_a_g,
   output logic [7:0]  act_a_b,
   output logic        a_pending
);

   // Channel index 0 = R, 1 = G, 2 = B throughout.
   logic [23:0] pix [9];
   logic [7:0]  a_in [3];
   logic [15:0] inv_in [3];

   logic [7:0]  act_a_q [3], act_a_d [3], sh_a_q [3], sh_a_d [3];
   logic [15:0] act_inv_q [3], act_inv_d [3], sh_inv_q [3], sh_inv_d [3];
   logic        pending_q, pending_d;

   logic [7:0]  s1_min_q [3], s1_min_d [3];
   logic [15:0] s1_inv_q [3], s1_inv_d [3];
   logic [23:0] s1_centre_q, s1_centre_d, s2_centre_q, s3_centre_q, centre_q;
   logic [23:0] prod [3];
   logic [15:0] s2_r_q [3], s2_r_d [3];
   logic [15:0] s3_d_q, s3_d_d;
   logic [15:0] t_raw, t_q, t_d;
   logic [3:0]  valid_q, valid_d;

   assign pix[0] = in_pixel_1;
   assign pix[1] = in_pixel_2;
   assign pix[2] = in_pixel_3;
   assign pix[3] = in_pixel_4;
   assign pix[4] = in_pixel_5;
   assign pix[5] = in_pixel_6;
   assign pix[6] = in_pixel_7;
   assign pix[7] = in_pixel_8;
   assign pix[8] = in_pixel_9;

   assign a_in[0]   = a_r;
   assign a_in[1]   = a_g;
   assign a_in[2]   = a_b;
   assign inv_in[0] = inv_a_r;
   assign inv_in[1] = inv_a_g;
   assign inv_in[2] = inv_a_b;

   always_comb begin
      // Swap reads the pre-edge shadow, so a coincident a_valid lands in the shadow only.
      for (int c = 0; c < 3; c++) begin
         act_a_d[c]   = (frame_start && pending_q) ? sh_a_q[c] : act_a_q[c];
         act_inv_d[c] = (frame_start && pending_q) ? sh_inv_q[c] : act_inv_q[c];
         sh_a_d[c]    = a_valid ? a_in[c] : sh_a_q[c];
         sh_inv_d[c]  = a_valid ? inv_in[c] : sh_inv_q[c];
      end
      pending_d = a_valid ? 1'b1 : (frame_start ? 1'b0 : pending_q);

      for (int c = 0; c < 3; c++) begin
         s1_min_d[c] = 8'hFF;
         s1_inv_d[c] = act_inv_q[c];
         for (int i = 0; i < 9; i++) begin
            if (pix[i][8*(2-c) +: 8] < s1_min_d[c]) s1_min_d[c] = pix[i][8*(2-c) +: 8];
         end
      end
      s1_centre_d = pix[4];

      for (int c = 0; c < 3; c++) begin
         prod[c]   = 24'(s1_min_q[c]) * 24'(s1_inv_q[c]);
         s2_r_d[c] = (prod[c][23:16] != 8'd0) ? 16'hFFFF : prod[c][15:0];
      end

      s3_d_d = s2_r_q[0];
      if (s2_r_q[1] < s3_d_d) s3_d_d = s2_r_q[1];
      if (s2_r_q[2] < s3_d_d) s3_d_d = s2_r_q[2];

      t_raw   = 16'hFFFF - 16'((24'(s3_d_q) * 24'(OMEGA_Q8)) >> 8);
      t_d     = (t_raw < 16'(T0_Q16)) ? 16'(T0_Q16) : t_raw;
      valid_d = {valid_q[2:0], in_valid};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int c = 0; c < 3; c++) begin
            act_a_q[c]   <= 8'd255;
            sh_a_q[c]    <= 8'd255;
            act_inv_q[c] <= 16'd257;
            sh_inv_q[c]  <= 16'd257;
            s1_min_q[c]  <= '0;
            s1_inv_q[c]  <= '0;
            s2_r_q[c]    <= '0;
         end
         pending_q   <= 1'b0;
         s1_centre_q <= '0;
         s2_centre_q <= '0;
         s3_centre_q <= '0;
         centre_q    <= '0;
         s3_d_q      <= '0;
         t_q         <= '0;
         valid_q     <= '0;
      end else begin
         for (int c = 0; c < 3; c++) begin
            act_a_q[c]   <= act_a_d[c];
            sh_a_q[c]    <= sh_a_d[c];
            act_inv_q[c] <= act_inv_d[c];
            sh_inv_q[c]  <= sh_inv_d[c];
            s1_min_q[c]  <= s1_min_d[c];
            s1_inv_q[c]  <= s1_inv_d[c];
            s2_r_q[c]    <= s2_r_d[c];
         end
         pending_q   <= pending_d;
         s1_centre_q <= s1_centre_d;
         s2_centre_q <= s1_centre_q;
         s3_centre_q <= s2_centre_q;
         centre_q    <= s3_centre_q;
         s3_d_q      <= s3_d_d;
         t_q         <= t_d;
         valid_q     <= valid_d;
      end
   end

   assign out_valid  = valid_q[3];
   assign t_out      = t_q;
   assign centre_out = centre_q;
   assign act_a_r    = act_a_q[0];
   assign act_a_g    = act_a_q[1];
   assign act_a_b    = act_a_q[2];
   assign a_pending  = pending_q;

endmodule
